spislaveio: RTL and testbench

SPISLAVEIO -- requirements
Module: spislaveio

---
 rtl/spislaveio.sv | 218 +++++++++++++++++++++
 tb/tb_spislaveio.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spislaveio.sv
// SPI mode-0 slave peripheral with a CPU-side register interface.
// The SPI pins are asynchronous to clk and are synchronized before use.
// A byte is received MSB first into RXBUF. The next transmit byte is taken
// from TXHOLD, or IDLE_BYTE when TXHOLD is empty.
//
// Transfer FSM states:
//   state    | meaning
//   ---------+------------------------------------------------------
//   S_IDLE   | no transfer; miso tristated; waiting for ss_n falling
//   S_ACTIVE | slave selected; shifting on sck edges; miso driven
module spislaveio #(
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       ss_n,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t     state, next_state;

    logic [1:0] ss_q, sck_q, mosi_q;
    logic       ss_prev, sck_prev;
    logic       ss_s, sck_s, mosi_s;
    logic       ss_fall, ss_rise, sck_rise, sck_fall;

    logic [2:0] bitcnt;
    logic [7:0] rxshift, rxbuf, txhold, txshift;
    logic       rxf, txe, ovr, udr;
    logic [2:0] ctrl;

    logic       wr, rd, sel_data, sel_status, sel_ctrl;
    logic       rd_data, wr_data, wr_status, wr_ctrl, en_clear;
    logic       tx_load, tx_shift_en, rx_shift_en, byte_done, abort;
    logic [7:0] rx_byte;

    // AD[2] is not decoded; the register map repeats every four addresses.
    logic       unused_ad;
    assign unused_ad = AD[2];

    assign ss_s   = ss_q[1];
    assign sck_s  = sck_q[1];
    assign mosi_s = mosi_q[1];

    assign ss_fall  = ss_prev & ~ss_s;
    assign ss_rise  = ~ss_prev & ss_s;
    assign sck_rise = ~sck_prev & sck_s;
    assign sck_fall = sck_prev & ~sck_s;

    assign wr         = cs & ~rw;
    assign rd         = cs & rw;
    assign sel_data   = (AD[1:0] == 2'd0);
    assign sel_status = (AD[1:0] == 2'd1);
    assign sel_ctrl   = (AD[1:0] == 2'd2);
    assign rd_data    = rd & sel_data;
    assign wr_data    = wr & sel_data;
    assign wr_status  = wr & sel_status;
    assign wr_ctrl    = wr & sel_ctrl;
    assign en_clear   = wr_ctrl & ~DI[0];

    assign rx_byte = {rxshift[6:0], mosi_s};

    assign miso    = txshift[7];
    assign miso_oe = (state == S_ACTIVE);

    // Two-flop synchronizers plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q     <= 2'b11;
            sck_q    <= 2'b00;
            mosi_q   <= 2'b00;
            ss_prev  <= 1'b1;
            sck_prev <= 1'b0;
        end else begin
            ss_q     <= {ss_q[0], ss_n};
            sck_q    <= {sck_q[0], sck};
            mosi_q   <= {mosi_q[0], mosi};
            ss_prev  <= ss_s;
            sck_prev <= sck_s;
        end
    end

    // Transfer FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next state and the per-cycle shift/load strobes.
    always_comb begin
        next_state  = state;
        tx_load     = 1'b0;
        tx_shift_en = 1'b0;
        rx_shift_en = 1'b0;
        byte_done   = 1'b0;
        abort       = 1'b0;
        case (state)
            S_IDLE: begin
                if (ss_fall && ctrl[0]) begin
                    next_state = S_ACTIVE;
                    tx_load    = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (ss_rise || en_clear) begin
                    next_state = S_IDLE;
                    abort      = 1'b1;
                end else begin
                    if (sck_rise) begin
                        rx_shift_en = 1'b1;
                        if (bitcnt == 3'd7) begin
                            byte_done = 1'b1;
                            tx_load   = 1'b1;
                        end
                    end
                    // The first falling edge after a reload must keep the
                    // freshly loaded MSB on miso.
                    if (sck_fall && (bitcnt != 3'd0)) tx_shift_en = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Bit counter and receive shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitcnt  <= 3'd0;
            rxshift <= 8'h00;
        end else if (abort || (state == S_IDLE)) begin
            bitcnt  <= 3'd0;
        end else if (rx_shift_en) begin
            bitcnt  <= bitcnt + 3'd1;
            rxshift <= rx_byte;
        end
    end

    // Receive buffer and its full/overrun flags; a same-cycle DATA read frees the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxbuf <= 8'h00;
            rxf   <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            if (rd_data) rxf <= 1'b0;
            if (wr_status && DI[2]) ovr <= 1'b0;
            if (byte_done) begin
                if (!rxf || rd_data) begin
                    rxbuf <= rx_byte;
                    rxf   <= 1'b1;
                end else begin
                    ovr   <= 1'b1;
                end
            end
        end
    end

    // Transmit path: reload uses pre-write TXHOLD, then a DATA write refills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            txhold  <= 8'h00;
            txshift <= IDLE_BYTE;
            txe     <= 1'b1;
            udr     <= 1'b0;
        end else begin
            if (wr_status && DI[3]) udr <= 1'b0;
            if (tx_load) begin
                if (!txe) begin
                    txshift <= txhold;
                    txe     <= 1'b1;
                end else begin
                    txshift <= IDLE_BYTE;
                    udr     <= 1'b1;
                end
            end else if (tx_shift_en) begin
                txshift <= {txshift[6:0], 1'b0};
            end
            if (wr_data) begin
                txhold <= DI;
                txe    <= 1'b0;
            end
        end
    end

    // Control register and registered interrupt request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl <= 3'b000;
            irq  <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= DI[2:0];
            irq <= ctrl[0] & ((rxf & ctrl[1]) | (txe & ctrl[2]));
        end
    end

    // CPU read mux.
    always_comb begin
        DO = 8'h00;
        case (AD[1:0])
            2'd0:    DO = rxbuf;
            2'd1:    DO = {3'b000, ~ss_s, udr, ovr, txe, rxf};
            2'd2:    DO = {5'b00000, ctrl};
            default: DO = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_spislaveio.sv
// Self-checking bench for spislaveio: register table, directed SPI
// corner cases and a randomized run against a byte-level model.
module tb_spislaveio;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] AD = 3'd0;
    logic [7:0] DI = 8'h00;
    logic [7:0] DO;
    logic       rw = 1'b1;
    logic       cs = 1'b0;
    logic       irq;
    logic       ss_n = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;

    int n_cmp = 0;
    int n_err = 0;

    spislaveio #(.IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
        .irq(irq), .ss_n(ss_n), .sck(sck), .mosi(mosi), .miso(miso),
        .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic       rw;
        logic [2:0] ad;
        logic [7:0] di;
        logic [7:0] exp;
    } vec_t;
    vec_t vt[18];

    // byte-level reference model
    logic       m_rxf, m_txe, m_ovr, m_udr;
    logic [7:0] m_rxbuf, m_txhold, m_shift;
    logic [2:0] m_ctrl;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0; cs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; AD = a;
        #2 d = DO;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] r;
        cpu_rd(a, r);
        chk(nm, r, exp);
    endtask

    task automatic ss_low();
        @(negedge clk);
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // hook: 0 none, 1 DATA read, 2 DATA write landing in the byte-complete cycle
    task automatic spi_byte(input logic [7:0] tx, input int hook, input logic [7:0] hdi,
                            output logic [7:0] rx, output logic [7:0] hdo);
        hdo = 8'h00;
        rx  = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (8) @(negedge clk);
            rx[i] = miso;
            sck = 1'b1;
            if (i == 0 && hook != 0) begin
                repeat (2) @(negedge clk);
                cs = 1'b1; rw = (hook == 1); AD = 3'd0; DI = hdi;
                #2 hdo = DO;
                @(negedge clk);
                cs = 1'b0; rw = 1'b1;
                repeat (5) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
            sck = 1'b0;
        end
    endtask

    task automatic spi_bits(input int n, input logic [7:0] pat);
        for (int i = 0; i < n; i++) begin
            mosi = pat[7-i];
            repeat (8) @(negedge clk);
            sck = 1'b1;
            repeat (8) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic m_reset();
        m_rxf = 0; m_txe = 1; m_ovr = 0; m_udr = 0;
        m_rxbuf = 8'h00; m_txhold = 8'h00; m_shift = 8'hFF; m_ctrl = 3'b000;
    endtask

    task automatic m_load();
        if (!m_txe) begin
            m_shift = m_txhold;
            m_txe = 1;
        end else begin
            m_shift = 8'hFF;
            m_udr = 1;
        end
    endtask

    task automatic m_done(input logic [7:0] b);
        if (!m_rxf) begin
            m_rxbuf = b;
            m_rxf = 1;
        end else begin
            m_ovr = 1;
        end
        m_load();
    endtask

    function automatic logic [7:0] m_status();
        return {4'b0000, m_udr, m_ovr, m_txe, m_rxf};
    endfunction

    function automatic logic m_irq();
        return m_ctrl[0] & ((m_rxf & m_ctrl[1]) | (m_txe & m_ctrl[2]));
    endfunction

    logic [7:0] r, hd, d;
    int         op, nb;

    initial begin
        vt[0]  = '{1'b1, 3'd1, 8'h00, 8'h02};
        vt[1]  = '{1'b1, 3'd2, 8'h00, 8'h00};
        vt[2]  = '{1'b1, 3'd3, 8'h00, 8'h00};
        vt[3]  = '{1'b1, 3'd0, 8'h00, 8'h00};
        vt[4]  = '{1'b0, 3'd2, 8'h07, 8'h00};
        vt[5]  = '{1'b1, 3'd2, 8'h00, 8'h07};
        vt[6]  = '{1'b1, 3'd6, 8'h00, 8'h07};
        vt[7]  = '{1'b0, 3'd2, 8'hFF, 8'h00};
        vt[8]  = '{1'b1, 3'd2, 8'h00, 8'h07};
        vt[9]  = '{1'b0, 3'd3, 8'h55, 8'h00};
        vt[10] = '{1'b1, 3'd3, 8'h00, 8'h00};
        vt[11] = '{1'b0, 3'd0, 8'hA5, 8'h00};
        vt[12] = '{1'b1, 3'd1, 8'h00, 8'h00};
        vt[13] = '{1'b0, 3'd5, 8'hFF, 8'h00};
        vt[14] = '{1'b1, 3'd1, 8'h00, 8'h00};
        vt[15] = '{1'b1, 3'd0, 8'h00, 8'h00};
        vt[16] = '{1'b0, 3'd2, 8'h00, 8'h00};
        vt[17] = '{1'b1, 3'd2, 8'h00, 8'h00};

        repeat (3) @(negedge clk);
        do_reset();
        chk("reset_irq", {7'b0, irq}, 8'h00);
        chk("reset_miso_oe", {7'b0, miso_oe}, 8'h00);

        // register map table
        for (int i = 0; i < 18; i++) begin
            if (vt[i].rw) begin
                cpu_rd(vt[i].ad, r);
                chk($sformatf("table_%0d", i), r, vt[i].exp);
            end else begin
                cpu_wr(vt[i].ad, vt[i].di);
            end
            if (i == 5) begin
                repeat (2) @(negedge clk);
                chk("table_irq_txe", {7'b0, irq}, 8'h01);
            end
        end

        // basic transfer
        do_reset();
        cpu_wr(3'd2, 8'h03);
        cpu_wr(3'd0, 8'hA5);
        ss_low();
        chk("basic_miso_oe", {7'b0, miso_oe}, 8'h01);
        spi_byte(8'h3C, 0, 8'h00, r, hd);
        chk("basic_miso", r, 8'hA5);
        repeat (3) @(negedge clk);
        rd_chk("basic_status", 3'd1, 8'h1B);
        chk("basic_irq_on", {7'b0, irq}, 8'h01);
        rd_chk("basic_data", 3'd0, 8'h3C);
        repeat (2) @(negedge clk);
        chk("basic_irq_off", {7'b0, irq}, 8'h00);
        rd_chk("basic_status2", 3'd1, 8'h1A);
        ss_high();
        chk("basic_miso_oe_off", {7'b0, miso_oe}, 8'h00);

        // underrun
        do_reset();
        cpu_wr(3'd2, 8'h01);
        ss_low();
        spi_byte(8'h00, 0, 8'h00, r, hd);
        ss_high();
        chk("udr_miso", r, 8'hFF);
        rd_chk("udr_status", 3'd1, 8'h0B);
        cpu_wr(3'd1, 8'h08);
        rd_chk("udr_cleared", 3'd1, 8'h03);

        // overrun
        do_reset();
        cpu_wr(3'd2, 8'h01);
        ss_low();
        spi_byte(8'h11, 0, 8'h00, r, hd);
        spi_byte(8'h22, 0, 8'h00, r, hd);
        ss_high();
        rd_chk("ovr_status", 3'd1, 8'h0F);
        rd_chk("ovr_data", 3'd0, 8'h11);
        rd_chk("ovr_status2", 3'd1, 8'h0E);
        cpu_wr(3'd1, 8'h04);
        rd_chk("ovr_cleared", 3'd1, 8'h0A);

        // mid-byte abort
        do_reset();
        cpu_wr(3'd2, 8'h01);
        ss_low();
        spi_bits(5, 8'hE7);
        ss_high();
        rd_chk("abort_status", 3'd1, 8'h0A);
        ss_low();
        spi_byte(8'h5A, 0, 8'h00, r, hd);
        ss_high();
        rd_chk("abort_data", 3'd0, 8'h5A);

        // DATA read in the byte-complete cycle
        do_reset();
        cpu_wr(3'd2, 8'h01);
        ss_low();
        spi_byte(8'h11, 0, 8'h00, r, hd);
        spi_byte(8'h22, 1, 8'h00, r, hd);
        chk("simA_old_data", hd, 8'h11);
        cpu_rd(3'd1, r);
        chk("simA_rxf_ovr", r & 8'h05, 8'h01);
        rd_chk("simA_new_data", 3'd0, 8'h22);
        ss_high();

        // DATA write in the reload cycle
        do_reset();
        cpu_wr(3'd2, 8'h01);
        cpu_wr(3'd0, 8'h77);
        ss_low();
        cpu_wr(3'd0, 8'h88);
        spi_byte(8'h01, 2, 8'h99, r, hd);
        chk("simB_byte1", r, 8'h77);
        cpu_rd(3'd1, r);
        chk("simB_txe", r & 8'h02, 8'h00);
        spi_byte(8'h02, 0, 8'h00, r, hd);
        chk("simB_byte2", r, 8'h88);
        spi_byte(8'h03, 0, 8'h00, r, hd);
        chk("simB_byte3", r, 8'h99);
        ss_high();

        // reset mid-transfer
        do_reset();
        cpu_wr(3'd2, 8'h07);
        cpu_wr(3'd0, 8'h33);
        ss_low();
        spi_bits(4, 8'hF0);
        @(negedge clk);
        rst = 1'b1; ss_n = 1'b1; sck = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rd_chk("rstmid_status", 3'd1, 8'h02);
        rd_chk("rstmid_ctrl", 3'd2, 8'h00);
        chk("rstmid_miso_oe", {7'b0, miso_oe}, 8'h00);
        chk("rstmid_irq", {7'b0, irq}, 8'h00);
        cpu_wr(3'd2, 8'h01);
        cpu_wr(3'd0, 8'hC3);
        ss_low();
        spi_byte(8'h96, 0, 8'h00, r, hd);
        ss_high();
        chk("rstmid_miso", r, 8'hC3);
        rd_chk("rstmid_data", 3'd0, 8'h96);

        // randomized run against the model
        do_reset();
        m_reset();
        cpu_wr(3'd2, 8'h07);
        m_ctrl = 3'b111;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: begin
                    d = 8'($urandom);
                    cpu_wr(3'd0, d);
                    m_txhold = d;
                    m_txe = 1'b0;
                end
                1: begin
                    cpu_rd(3'd0, r);
                    chk("rnd_data", r, m_rxbuf);
                    m_rxf = 1'b0;
                end
                2, 3: begin
                    nb = $urandom_range(1, 3);
                    ss_low();
                    chk("rnd_miso_oe", {7'b0, miso_oe}, {7'b0, m_ctrl[0]});
                    if (m_ctrl[0]) m_load();
                    for (int b = 0; b < nb; b++) begin
                        d = 8'($urandom);
                        spi_byte(d, 0, 8'h00, r, hd);
                        if (m_ctrl[0]) begin
                            chk("rnd_miso", r, m_shift);
                            m_done(d);
                        end
                    end
                    ss_high();
                end
                4: begin
                    d = 8'($urandom);
                    cpu_wr(3'd1, d);
                    if (d[2]) m_ovr = 1'b0;
                    if (d[3]) m_udr = 1'b0;
                end
                default: begin
                    d = 8'($urandom);
                    if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                    cpu_wr(3'd2, d);
                    m_ctrl = d[2:0];
                end
            endcase
            cpu_rd(3'd1, r);
            chk("rnd_status", r, m_status());
            repeat (2) @(negedge clk);
            chk("rnd_irq", {7'b0, irq}, {7'b0, m_irq()});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
